vsq_readout: RTL

- Drains the post-processing VSQ row buffer: one 296-bit row holds 16 lanes of 18-bit unsigned post-ReLU values.
- For each row, finds the vector max and derives a per-vector shift exponent.
- Quantizes all 16 lanes to 8 bits and emits a 136-bit packed word (16×8 data + 8-bit exponent) over a valid/ready handshake.
- Sits between the PPU row buffer's read port and the output writeback path.

---
 rtl/vsq_pkg.sv | 34 +++
 rtl/vsq_max_shift.sv | 45 ++++
 rtl/vsq_readout.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/vsq_pkg.sv
// -----------------------------------------------------------------------------
// vsq_pkg
// Shared constants and types for the VSQ readout block.
//   Row format : LANES x ELEM_W unsigned lanes, lane j = [j*ELEM_W +: ELEM_W],
//                padded to ROW_W bits (upper pad ignored).
//   Out format : {exponent[EXP_W-1:0], q15 .. q0}, lane j = [j*Q_W +: Q_W].
// -----------------------------------------------------------------------------
package vsq_pkg;

  localparam int LANES   = 16;
  localparam int ELEM_W  = 18;
  localparam int Q_W     = 8;
  localparam int ROW_W   = 296;
  localparam int OUT_W   = 136;
  localparam int ROWS    = 48;
  localparam int ADDR_W  = 6;

  // Derived widths.
  localparam int DATA_W  = LANES * ELEM_W;       // 288 meaningful row bits
  localparam int QDATA_W = LANES * Q_W;          // 128 quantized data bits
  localparam int EXP_W   = OUT_W - QDATA_W;      // 8-bit exponent field
  localparam int SHIFT_W = 4;                    // shift range 0..10
  localparam int MSB_W   = $clog2(ELEM_W);       // index of a bit in a lane

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_MAX,
    S_QUANT,
    S_OUT
  } state_e;

endpackage

// File: rtl/vsq_max_shift.sv
// -----------------------------------------------------------------------------
// vsq_max_shift
// Combinational vector max over all lanes of a row plus a leading-one detector
// that turns the max into a right-shift exponent: the smallest shift that
// brings vmax into Q_W bits.
//   i_row   : DATA_W  packed lanes, lane j = [j*ELEM_W +: ELEM_W]
//   o_vmax  : ELEM_W  unsigned max of all lanes
//   o_shift : SHIFT_W 0 when vmax < 2**Q_W, else msb(vmax) - (Q_W-1)
// -----------------------------------------------------------------------------
module vsq_max_shift
  import vsq_pkg::*;
(
  input  logic [DATA_W-1:0]  i_row,
  output logic [ELEM_W-1:0]  o_vmax,
  output logic [SHIFT_W-1:0] o_shift
);

  logic [MSB_W-1:0] w_msb;
  logic             w_small;

  // NOTE: every variable written in an always_comb gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    o_vmax = '0;
    for (int j = 0; j < LANES; j++) begin
      if (i_row[j*ELEM_W +: ELEM_W] > o_vmax) begin
        o_vmax = i_row[j*ELEM_W +: ELEM_W];
      end
    end
  end

  // Leading-one detector: the highest set bit wins because it is visited last.
  always_comb begin
    w_msb = '0;
    for (int i = 0; i < ELEM_W; i++) begin
      if (o_vmax[i]) begin
        w_msb = MSB_W'(i);
      end
    end
  end

  assign w_small = (o_vmax[ELEM_W-1:Q_W] == '0);
  assign o_shift = w_small ? '0 : SHIFT_W'(w_msb - MSB_W'(Q_W - 1));

endmodule

// File: rtl/vsq_readout.sv
// -----------------------------------------------------------------------------
// vsq_readout
// Drains the post-processing VSQ row buffer. Each row is read, its vector max
// and shift exponent are found, every lane is quantized to Q_W bits and the
// packed {exponent, q15..q0} word is offered on a valid/ready handshake.
// One row takes five cycles: REQ, WAIT, MAX, QUANT, OUT.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : one-cycle pulse, drains num_rows rows from address 0
//   num_rows     : row count, clamped to ROWS, sampled on an accepted start
//   buf_rd_en    : buffer read strobe (one cycle per row)
//   buf_rd_addr  : row address
//   buf_rd_data  : row data, valid the cycle after buf_rd_en
//   out_valid    : out_data valid, held until out_ready
//   out_ready    : downstream accept
//   out_data     : {shift (zero-extended), q15 .. q0}
//   busy         : high outside IDLE
//   done         : one-cycle pulse after the last row is accepted
//
// Build option:
//   VSQ_ROUND_EN : round-half-up with saturation to 255 instead of truncation.
// -----------------------------------------------------------------------------
module vsq_readout
  import vsq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_rows,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  input  logic [ROW_W-1:0]  buf_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              busy,
  output logic              done
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [ADDR_W-1:0]    r_n;
  logic [ADDR_W-1:0]    r_idx;
  logic [DATA_W-1:0]    r_row;
  logic [ELEM_W-1:0]    r_vmax;
  logic [SHIFT_W-1:0]   r_shift;
  logic [OUT_W-1:0]     r_out_data;
  logic                 r_out_valid;
  logic                 r_done;

  logic [ELEM_W-1:0]    w_vmax;
  logic [SHIFT_W-1:0]   w_shift;
  logic [QDATA_W-1:0]   w_q;
  logic                 w_last;
  logic                 w_unused_pad;

  // Upper pad bits of a buffer row carry no lane data.
  assign w_unused_pad = ^buf_rd_data[ROW_W-1:DATA_W];

  // Quantize one lane. lane <= vmax guarantees the truncated result fits Q_W
  // bits; the rounding increment can carry past it, hence the clamp.
  function automatic logic [Q_W-1:0] quant_lane(input logic [ELEM_W-1:0]  lane,
                                                input logic [SHIFT_W-1:0] sh);
`ifdef VSQ_ROUND_EN
    localparam logic [ELEM_W:0] ONE = 1;
    logic [ELEM_W:0] sum;
    logic [ELEM_W:0] shifted;
    sum     = {1'b0, lane} + ((sh != '0) ? (ONE << (sh - 1'b1)) : '0);
    shifted = sum >> sh;
    return (|shifted[ELEM_W:Q_W]) ? {Q_W{1'b1}} : shifted[Q_W-1:0];
`else
    logic [ELEM_W-1:0] shifted;
    shifted = lane >> sh;
    return shifted[Q_W-1:0];
`endif
  endfunction

  vsq_max_shift u_max_shift (
    .i_row   (r_row),
    .o_vmax  (w_vmax),
    .o_shift (w_shift)
  );

  // A row whose max already fits Q_W bits is passed straight through.
  always_comb begin
    w_q = '0;
    for (int j = 0; j < LANES; j++) begin
      w_q[j*Q_W +: Q_W] = (r_vmax[ELEM_W-1:Q_W] == '0)
                        ? r_row[j*ELEM_W +: Q_W]
                        : quant_lane(r_row[j*ELEM_W +: ELEM_W], r_shift);
    end
  end

  assign w_last = (r_idx == r_n - 1'b1);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: clocked state is assigned with <= only, so every flop samples the
  // pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && (num_rows != '0)) w_state_nxt = S_REQ;
      S_REQ:   w_state_nxt = S_WAIT;
      S_WAIT:  w_state_nxt = S_MAX;
      S_MAX:   w_state_nxt = S_QUANT;
      S_QUANT: w_state_nxt = S_OUT;
      S_OUT:   if (out_ready) w_state_nxt = w_last ? S_IDLE : S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n         <= '0;
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (num_rows == '0) begin
              r_done <= 1'b1;
            end else begin
              r_n   <= (num_rows > ADDR_W'(ROWS)) ? ADDR_W'(ROWS) : num_rows;
              r_idx <= '0;
            end
          end
        end
        S_QUANT: begin
          r_out_data  <= {{(EXP_W - SHIFT_W){1'b0}}, r_shift, w_q};
          r_out_valid <= 1'b1;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_last) begin
              r_done <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Row datapath
  // ---------------------------------------------------------------------------
  // NOTE: these wide data registers carry no reset; they are always written
  // (WAIT, MAX) before being read, and leaving them unreset keeps the reset
  // tree off the row-sized datapath.
  always_ff @(posedge clk) begin
    if (r_state == S_WAIT) begin
      r_row <= buf_rd_data[DATA_W-1:0];
    end
    if (r_state == S_MAX) begin
      r_vmax  <= w_vmax;
      r_shift <= w_shift;
    end
  end

  assign buf_rd_en   = (r_state == S_REQ);
  assign buf_rd_addr = r_idx;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;

endmodule
